wb_mc_slave_bridge: RTL and testbench

//  Wishbone classic slave front-end of the memory controller; its pins are the slave side of the WB bus the UVC drives.

---
 rtl/wb_mc_slave_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_wb_mc_slave_bridge.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mc_slave_bridge.sv
// Wishbone classic slave front-end: posts writes, forwards reads in order.
// Define WB_MC_RD_TIMEOUT_EN to bound the read wait by RD_TIMEOUT cycles.
module wb_mc_slave_bridge #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE  = 32'h0100_0000,
   parameter int unsigned RD_TIMEOUT = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wb_data_i,
   input  logic [31:0] wb_addr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_data_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic        cmd_we_o,
   output logic [31:0] cmd_addr_o,
   output logic [31:0] cmd_data_o,
   output logic [3:0]  cmd_sel_o,
   input  logic        rd_valid_i,
   input  logic [31:0] rd_data_i,
   input  logic        rd_err_i
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (RD_TIMEOUT == 0) begin : g_bad_tmo
      $error("RD_TIMEOUT must be at least 1");
   end

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_ACK,
      RD_WAIT,
      RD_ACK,
      ERR,
      DRAIN
   } state_t;

   cmd_t          mem_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   state_t        state_q;
   logic          ack_q;
   logic          err_q;
   logic [31:0]   rdata_q;

   logic          req;
   logic          in_range;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   cmd_t          head;
   cmd_t          entry;

`ifdef WB_MC_RD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
   logic [TW-1:0] tmo_q;
   logic          tmo_err_q;
`endif

   // Wrap-safe window test: a single unsigned compare after rebasing.
   assign in_range = (wb_addr_i - BASE_ADDR) < ADDR_SIZE;
   assign req      = wb_cyc_i & wb_stb_i;
   assign full     = cnt_q == CW'(FIFO_DEPTH);
   assign empty    = cnt_q == '0;
   assign push     = (state_q == IDLE) & req & in_range & ~full;
   assign pop      = ~empty & cmd_ready_i;

   assign entry.we   = wb_we_i;
   assign entry.addr = wb_addr_i;
   assign entry.data = wb_data_i;
   assign entry.sel  = wb_sel_i;

   assign head        = mem_q[rptr_q];
   assign cmd_valid_o = ~empty;
   assign cmd_we_o    = ~empty & head.we;
   assign cmd_addr_o  = empty ? '0 : head.addr;
   assign cmd_data_o  = empty ? '0 : head.data;
   assign cmd_sel_o   = empty ? '0 : head.sel;

   assign wb_data_o = rdata_q;
   assign wb_ack_o  = ack_q;
   assign wb_err_o  = err_q;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= entry;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
`ifdef WB_MC_RD_TIMEOUT_EN
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  if (!in_range) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else if (!full) begin
                     if (wb_we_i) begin
                        state_q <= WR_ACK;
                        ack_q   <= 1'b1;
                     end else begin
                        state_q <= RD_WAIT;
`ifdef WB_MC_RD_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                     end
                  end
               end
            end
            WR_ACK, RD_ACK: begin
               state_q <= IDLE;
            end
            RD_WAIT: begin
               // A response coinciding with abandonment is simply consumed.
               if (rd_valid_i) begin
                  if (!wb_cyc_i) begin
                     state_q <= IDLE;
                  end else if (rd_err_i) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= RD_ACK;
                     ack_q   <= 1'b1;
                     rdata_q <= rd_data_i;
                  end
               end else if (!wb_cyc_i) begin
                  state_q <= DRAIN;
`ifdef WB_MC_RD_TIMEOUT_EN
               end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
                  state_q   <= ERR;
                  err_q     <= 1'b1;
                  tmo_err_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
`endif
               end
            end
            ERR: begin
`ifdef WB_MC_RD_TIMEOUT_EN
               // A timed-out read still owes one response; swallow it.
               if (tmo_err_q) begin
                  state_q   <= DRAIN;
                  tmo_err_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
`else
               state_q <= IDLE;
`endif
            end
            DRAIN: begin
               if (rd_valid_i) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_mc_slave_bridge.sv
// Self-checking bench for wb_mc_slave_bridge: WB master tasks,
// a memory-backed core model and a byte-level reference memory.
module tb_wb_mc_slave_bridge;

   localparam int TMO = 8;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] wb_data_i = '0;
   logic [31:0] wb_addr_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [31:0] wb_data_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i = 1'b0;
   logic        cmd_we_o;
   logic [31:0] cmd_addr_o;
   logic [31:0] cmd_data_o;
   logic [3:0]  cmd_sel_o;
   logic        rd_valid_i = 1'b0;
   logic [31:0] rd_data_i = '0;
   logic        rd_err_i = 1'b0;

   int ncmp = 0;
   int nerr = 0;
   int cyc_n = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } cmd_s;

   cmd_s        exp_q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] be_mem [logic [31:0]];

   int          ready_mode = 0;
   logic        man_ready = 1'b0;
   logic        rd_flag = 1'b0;
   int          rd_lat = 2;
   logic        rsp_err = 1'b0;
   logic        rsp_hold = 1'b0;
   int          pend = 0;
   logic [31:0] pend_data = '0;
   logic        pend_err = 1'b0;
   int          pops = 0;
   int          last_rdv = 0;

   wb_mc_slave_bridge #(
      .FIFO_DEPTH(4),
      .RD_TIMEOUT(TMO)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wb_data_i  (wb_data_i),
      .wb_addr_i  (wb_addr_i),
      .wb_sel_i   (wb_sel_i),
      .wb_we_i    (wb_we_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_data_o  (wb_data_o),
      .wb_ack_o   (wb_ack_o),
      .wb_err_o   (wb_err_o),
      .cmd_valid_o(cmd_valid_o),
      .cmd_ready_i(cmd_ready_i),
      .cmd_we_o   (cmd_we_o),
      .cmd_addr_o (cmd_addr_o),
      .cmd_data_o (cmd_data_o),
      .cmd_sel_o  (cmd_sel_o),
      .rd_valid_i (rd_valid_i),
      .rd_data_i  (rd_data_i),
      .rd_err_i   (rd_err_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc_n++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic in_win(input logic [31:0] a);
      return a < 32'h0100_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] be_rd(input logic [31:0] a);
      return be_mem.exists(a) ? be_mem[a] : 32'h0;
   endfunction

   // Core model: memory backend, checks every popped command in order.
   always @(posedge clk_i) begin : core
      cmd_s e;
      #2;
      rd_valid_i = 1'b0;
      rd_err_i   = 1'b0;
      if (!rst_i) begin
         pend = 0;
      end else begin
         if (pend > 0 && !rsp_hold) begin
            pend--;
            if (pend == 0) begin
               rd_valid_i = 1'b1;
               rd_data_i  = pend_data;
               rd_err_i   = pend_err;
               last_rdv   = cyc_n;
            end
         end
         case (ready_mode)
            0:       cmd_ready_i = 1'b1;
            1:       cmd_ready_i = man_ready;
            default: cmd_ready_i = rd_flag ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
         if (cmd_valid_o && cmd_ready_i) begin
            pops++;
            ncmp++;
            if (exp_q.size() == 0) begin
               nerr++;
               $display("FAIL cmd_pop: unexpected cmd addr=%h, required none",
                        cmd_addr_o);
            end else begin
               e = exp_q.pop_front();
               if (cmd_we_o !== e.we || cmd_addr_o !== e.addr ||
                   cmd_sel_o !== e.sel || (e.we && cmd_data_o !== e.data)) begin
                  nerr++;
                  $display("FAIL cmd_pop: got we=%b a=%h d=%h s=%h, required we=%b a=%h d=%h s=%h",
                           cmd_we_o, cmd_addr_o, cmd_data_o, cmd_sel_o,
                           e.we, e.addr, e.data, e.sel);
               end
            end
            if (cmd_we_o) begin
               be_mem[cmd_addr_o] = merge(be_rd(cmd_addr_o), cmd_data_o, cmd_sel_o);
            end else begin
               pend      = rd_lat;
               pend_data = be_rd(cmd_addr_o);
               pend_err  = rsp_err;
            end
         end
      end
   end

   task automatic wb_start(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      @(negedge clk_i);
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = we;
      wb_addr_i = a;
      wb_data_i = d;
      wb_sel_i  = s;
      if (in_win(a)) begin
         exp_q.push_back('{we: we, addr: a, data: d, sel: s});
         if (we) ref_mem[a] = merge(ref_rd(a), d, s);
      end
   endtask

   // res: 0 ack, 1 err, 2 nothing within budget, 3 ack and err together
   task automatic wb_wait(input int budget, output int res, output int lat);
      res = 2;
      lat = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) begin
            res = (wb_ack_o && wb_err_o) ? 3 : (wb_err_o ? 1 : 0);
            lat = i;
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            break;
         end
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input int budget, output int res, output int lat);
      wb_start(we, a, d, s);
      wb_wait(budget, res, lat);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      ncmp++;
      if ({wb_ack_o, wb_err_o, wb_data_o, cmd_valid_o, cmd_we_o,
           cmd_addr_o, cmd_data_o, cmd_sel_o} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: ack=%b err=%b data=%h cv=%b, required all 0",
                  wb_ack_o, wb_err_o, wb_data_o, cmd_valid_o);
      end
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_write();
      int res, lat;
      ready_mode = 0;
      wb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 20, res, lat);
      ncmp++;
      if (res !== 0 || lat !== 1) begin
         nerr++;
         $display("FAIL write_ack: res=%0d lat=%0d, required res=0 lat=1", res, lat);
      end
      ncmp++;
      if ({cmd_valid_o, cmd_we_o, cmd_addr_o, cmd_data_o, cmd_sel_o} !==
          {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
         nerr++;
         $display("FAIL write_cmd: v=%b we=%b a=%h d=%h, required 1 1 00000010 deadbeef",
                  cmd_valid_o, cmd_we_o, cmd_addr_o, cmd_data_o);
      end
      @(negedge clk_i);
      ncmp++;
      if (wb_ack_o !== 1'b0) begin
         nerr++;
         $display("FAIL write_ack_len: ack=%b one cycle later, required 0", wb_ack_o);
      end
   endtask

   task automatic test_fifo_full();
      int res, lat, p0;
      logic stalled;
      ready_mode = 1;
      man_ready  = 1'b0;
      repeat (3) @(negedge clk_i);
      for (int k = 0; k < 4; k++) begin
         wb_xfer(1'b1, 32'h100 + 32'(4*k), $urandom, 4'hF, 20, res, lat);
         ncmp++;
         if (res !== 0 || lat !== 1) begin
            nerr++;
            $display("FAIL fill_write%0d: res=%0d lat=%0d, required 0/1", k, res, lat);
         end
      end
      wb_start(1'b1, 32'h110, 32'hCAFE_0005, 4'h3);
      stalled = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) stalled = 1'b0;
      end
      ncmp++;
      if (stalled !== 1'b1) begin
         nerr++;
         $display("FAIL full_stall: fifth write terminated, required stall");
      end
      p0 = pops;
      man_ready = 1'b1;
      @(negedge clk_i);
      man_ready = 1'b0;
      wb_wait(10, res, lat);
      ncmp++;
      if (res !== 0 || lat !== 2) begin
         nerr++;
         $display("FAIL full_release: res=%0d lat=%0d, required 0/2", res, lat);
      end
      ncmp++;
      if (pops !== p0 + 1) begin
         nerr++;
         $display("FAIL full_pulse_pops: got %0d, required %0d", pops - p0, 1);
      end
      ready_mode = 0;
      repeat (8) @(negedge clk_i);
      ncmp++;
      if (pops !== p0 + 5 || cmd_valid_o !== 1'b0 || exp_q.size() != 0) begin
         nerr++;
         $display("FAIL full_drain: pops=%0d cv=%b, required 5 and 0", pops - p0, cmd_valid_o);
      end
   endtask

   task automatic test_read();
      int res, lat, ack_cyc;
      ready_mode = 0;
      rd_lat     = 3;
      wb_xfer(1'b1, 32'h20, 32'h1234_5678, 4'hF, 20, res, lat);
      wb_xfer(1'b0, 32'h20, $urandom, 4'hF, 40, res, lat);
      ack_cyc = cyc_n;
      ncmp++;
      if (res !== 0 || lat !== 5 || wb_data_o !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL read_ack: res=%0d lat=%0d data=%h, required 0/5/12345678",
                  res, lat, wb_data_o);
      end
      ncmp++;
      if (ack_cyc - last_rdv !== 1) begin
         nerr++;
         $display("FAIL read_ack_delay: got %0d cycles, required 1", ack_cyc - last_rdv);
      end
      repeat (3) @(negedge clk_i);
      wb_xfer(1'b1, 32'h24, 32'h5555_AAAA, 4'hF, 20, res, lat);
      ncmp++;
      if (wb_data_o !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL read_hold: data=%h, required 12345678", wb_data_o);
      end
   endtask

   task automatic test_errors();
      int res, lat, p0;
      ready_mode = 0;
      rd_lat     = 2;
      repeat (2) @(negedge clk_i);
      p0 = pops;
      wb_xfer(1'b1, 32'h0100_0000, 32'h1, 4'hF, 20, res, lat);
      ncmp++;
      if (res !== 1 || lat !== 1) begin
         nerr++;
         $display("FAIL oor_first: res=%0d lat=%0d, required 1/1", res, lat);
      end
      @(negedge clk_i);
      ncmp++;
      if (wb_err_o !== 1'b0) begin
         nerr++;
         $display("FAIL oor_err_len: err=%b, required 0", wb_err_o);
      end
      wb_xfer(1'b0, 32'hFFFF_FFFC, 32'h2, 4'hF, 20, res, lat);
      ncmp++;
      if (res !== 1) begin
         nerr++;
         $display("FAIL oor_wrap: res=%0d, required 1", res);
      end
      repeat (3) @(negedge clk_i);
      ncmp++;
      if (pops !== p0) begin
         nerr++;
         $display("FAIL oor_nopush: pops=%0d, required 0", pops - p0);
      end
      wb_xfer(1'b1, 32'h00FF_FFFC, 32'h0BAD_F00D, 4'hF, 20, res, lat);
      ncmp++;
      if (res !== 0) begin
         nerr++;
         $display("FAIL top_in_range: res=%0d, required 0", res);
      end
      rsp_err = 1'b1;
      wb_xfer(1'b0, 32'h00FF_FFFC, 32'h0, 4'hF, 40, res, lat);
      rsp_err = 1'b0;
      ncmp++;
      if (res !== 1 || wb_data_o !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL rd_err: res=%0d data=%h, required 1/12345678", res, wb_data_o);
      end
   endtask

   task automatic test_reset_mid();
      int res, lat;
      ready_mode = 1;
      man_ready  = 1'b0;
      repeat (2) @(negedge clk_i);
      wb_xfer(1'b1, 32'h40, 32'h7777_0000, 4'hF, 20, res, lat);
      wb_start(1'b0, 32'h44, 32'h0, 4'hF);
      repeat (3) @(negedge clk_i);
      ncmp++;
      if (cmd_valid_o !== 1'b1 || wb_data_o === 32'h0) begin
         nerr++;
         $display("FAIL pre_reset: cv=%b data=%h, required 1 and nonzero", cmd_valid_o, wb_data_o);
      end
      #2 rst_i = 1'b0;
      #1;
      ncmp++;
      if ({wb_ack_o, wb_err_o, wb_data_o, cmd_valid_o, cmd_we_o,
           cmd_addr_o, cmd_data_o, cmd_sel_o} !== '0) begin
         nerr++;
         $display("FAIL mid_reset: ack=%b err=%b data=%h cv=%b a=%h, required all 0",
                  wb_ack_o, wb_err_o, wb_data_o, cmd_valid_o, cmd_addr_o);
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      exp_q.delete();
      ref_mem = be_mem;
      repeat (2) @(negedge clk_i);
      rst_i      = 1'b1;
      ready_mode = 0;
      wb_xfer(1'b1, 32'h48, 32'h0102_0304, 4'hF, 20, res, lat);
      ncmp++;
      if (res !== 0 || lat !== 1) begin
         nerr++;
         $display("FAIL post_reset_write: res=%0d lat=%0d, required 0/1", res, lat);
      end
      repeat (3) @(negedge clk_i);
      ncmp++;
      if (cmd_valid_o !== 1'b0 || exp_q.size() != 0) begin
         nerr++;
         $display("FAIL post_reset_fifo: cv=%b left=%0d, required 0/0", cmd_valid_o, exp_q.size());
      end
   endtask

   task automatic test_timeout();
      int res, lat;
      logic quiet;
      logic [31:0] expd;
      ready_mode = 0;
      rd_lat     = 2;
      expd       = ref_rd(32'h10);
      rsp_hold   = 1'b1;
`ifdef WB_MC_RD_TIMEOUT_EN
      wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, 40, res, lat);
      ncmp++;
      if (res !== 1 || lat !== TMO + 1) begin
         nerr++;
         $display("FAIL tmo_err: res=%0d lat=%0d, required 1/%0d", res, lat, TMO + 1);
      end
      repeat (3) @(negedge clk_i);
      rsp_hold = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) quiet = 1'b0;
      end
      ncmp++;
      if (quiet !== 1'b1) begin
         nerr++;
         $display("FAIL tmo_late_drop: late response terminated a cycle, required none");
      end
      wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, 40, res, lat);
      ncmp++;
      if (res !== 0 || wb_data_o !== expd) begin
         nerr++;
         $display("FAIL tmo_next_read: res=%0d data=%h, required 0/%h", res, wb_data_o, expd);
      end
`else
      wb_start(1'b0, 32'h10, 32'h0, 4'hF);
      quiet = 1'b1;
      for (int i = 0; i < 4 * TMO; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) quiet = 1'b0;
      end
      ncmp++;
      if (quiet !== 1'b1) begin
         nerr++;
         $display("FAIL no_tmo_wait: read terminated while held, required wait");
      end
      rsp_hold = 1'b0;
      wb_wait(20, res, lat);
      ncmp++;
      if (res !== 0 || wb_data_o !== expd) begin
         nerr++;
         $display("FAIL no_tmo_ack: res=%0d data=%h, required 0/%h", res, wb_data_o, expd);
      end
`endif
      rsp_hold = 1'b0;
   endtask

   task automatic test_random();
      int res, lat, bad;
      logic we, oor;
      logic [31:0] a, d, expd;
      logic [3:0] s;
      ready_mode = 2;
      bad = 0;
      for (int n = 0; n < 80; n++) begin
         we  = 1'($urandom_range(0, 1));
         oor = ($urandom_range(0, 9) == 0);
         a   = oor ? 32'h0100_0000 + 32'($urandom_range(0, 1023) * 4)
                   : 32'($urandom_range(0, 15) * 4);
         if (oor && $urandom_range(0, 1) == 1) a = 32'hFFFF_FFF0;
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         expd = ref_rd(a);
         rd_lat  = $urandom_range(1, 3);
         rd_flag = !we;
         wb_xfer(we, a, d, s, 60, res, lat);
         rd_flag = 1'b0;
         ncmp++;
         if (oor ? (res !== 1) : (res !== 0 || (!we && wb_data_o !== expd))) begin
            nerr++;
            $display("FAIL rand_%0d: we=%b a=%h res=%0d data=%h, required res=%0d data=%h",
                     n, we, a, res, wb_data_o, oor ? 1 : 0, expd);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end
      ready_mode = 0;
      repeat (8) @(negedge clk_i);
      ncmp++;
      if (exp_q.size() != 0 || cmd_valid_o !== 1'b0) begin
         nerr++;
         $display("FAIL rand_drain: left=%0d cv=%b, required 0/0", exp_q.size(), cmd_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_fifo_full();
      test_read();
      test_errors();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
